// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / phase sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_P2, S_P3, S_P4, S_P5, S_HALTED
  } state_e;

  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_P1   = 5'b00001;
  localparam logic [4:0] PH_P2   = 5'b00010;
  localparam logic [4:0] PH_P3   = 5'b00100;
  localparam logic [4:0] PH_P4   = 5'b01000;
  localparam logic [4:0] PH_P5   = 5'b10000;

  localparam logic [1:0] OP_ARITH = 2'b11;
  localparam logic [3:0] OP3_HLT  = 4'b1111;

  localparam int unsigned RESET_PC_DEFAULT = 0;

  function automatic logic is_hlt(input logic [15:0] cmd);
    return (cmd[15:14] == OP_ARITH) && (cmd[7:4] == OP3_HLT);
  endfunction

endpackage

// File: rtl/program_counter.sv
// PC register: synchronous reset load, target load has priority over increment.
module program_counter
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_inc,
  input  logic                i_load,
  input  logic [PC_WIDTH-1:0] i_target,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic [PC_WIDTH-1:0] r_pc;

  // Increment wraps naturally modulo 2^PC_WIDTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_target;
    else if (i_inc)  r_pc <= r_pc + PC_WIDTH'(1);
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch and five-phase sequencer producing COMMAND for the decoder.
// Define FETCH_SEQ_SINGLE_STEP_EN to add the step port and one-instruction-per-pulse mode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         COMMAND,
  output logic                cmd_valid,
  output logic [4:0]          phase,
  input  logic                PC_load,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  state_e              r_state, w_next;
  logic [15:0]         r_cmd;
  logic                w_inc, w_load, w_start, w_cont;
  logic [PC_WIDTH-1:0] w_pc;

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  assign w_start = run & step;
  assign w_cont  = 1'b0;
`else
  assign w_start = run;
  assign w_cont  = run;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                             r_cmd <= 16'h0000;
    else if (r_state == S_FETCH && imem_ack) r_cmd <= imem_rdata;
  end

  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_FETCH;
      S_FETCH:  if (imem_ack) begin
                  w_inc  = 1'b1;
                  w_next = S_P2;
                end
      S_P2:     w_next = S_P3;
      S_P3:     w_next = S_P4;
      S_P4:     w_next = S_P5;
      S_P5: begin
        w_load = PC_load & branch_taken;
        if (is_hlt(r_cmd)) w_next = S_HALTED;
        else if (w_cont)   w_next = S_FETCH;
        else               w_next = S_IDLE;
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    phase = PH_NONE;
    case (r_state)
      S_FETCH: phase = PH_P1;
      S_P2:    phase = PH_P2;
      S_P3:    phase = PH_P3;
      S_P4:    phase = PH_P4;
      S_P5:    phase = PH_P5;
      default: phase = PH_NONE;
    endcase
  end

  program_counter #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_inc    (w_inc),
    .i_load   (w_load),
    .i_target (branch_target),
    .o_pc     (w_pc)
  );

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = w_pc;
  assign pc        = w_pc;
  assign COMMAND   = r_cmd;
  assign cmd_valid = (r_state == S_P2) || (r_state == S_P3) ||
                     (r_state == S_P4) || (r_state == S_P5);
  assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: expected fetch addresses queued, observed ones compared.
module tb_fetch_sequencer;

  localparam logic [15:0] BR_WORD  = 16'h8000;
  localparam logic [15:0] HLT_WORD = 16'hC0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] COMMAND;
  logic        cmd_valid;
  logic [4:0]  phase;
  logic        PC_load = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] pc;
  logic        halted;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
  logic        step_w = 1'b1;
`endif

  // Narrow instance for wrap-around; ack held high to exercise ack outside FETCH.
  logic        run_w = 1'b0;
  logic        req_w;
  logic [3:0]  addr_w;
  logic        ack_w = 1'b1;
  logic [15:0] rdata_w = '0;
  logic [15:0] cmd_w;
  logic        cv_w;
  logic [4:0]  ph_w;
  logic        pcl_w = 1'b0;
  logic        bt_w = 1'b0;
  logic [3:0]  tgt_w = '0;
  logic [3:0]  pc_w;
  logic        halted_w;

  int checks = 0;
  int passed = 0;

  logic [15:0] mem [0:255];
  int          wait_n = 0;
  int          wcnt = 0;
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .COMMAND(COMMAND), .cmd_valid(cmd_valid),
    .phase(phase), .PC_load(PC_load), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .halted(halted)
  );

  fetch_sequencer #(.PC_WIDTH(4), .RESET_PC(4'hF)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w),
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    .step(step_w),
`endif
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w),
    .imem_rdata(rdata_w), .COMMAND(cmd_w), .cmd_valid(cv_w),
    .phase(ph_w), .PC_load(pcl_w), .branch_taken(bt_w),
    .branch_target(tgt_w), .pc(pc_w), .halted(halted_w)
  );

  // Memory with programmable wait states, plus a decoder stand-in flagging BR_WORD.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wcnt >= wait_n) begin imem_ack = 1'b1; wcnt = 0; end
      else begin imem_ack = 1'b0; wcnt = wcnt + 1; end
    end else begin
      imem_ack = 1'b0;
      wcnt = 0;
    end
    imem_rdata = mem[imem_addr[7:0]];
    PC_load = (COMMAND == BR_WORD);
  end

  always @(negedge clk) begin
    #1;
    if (imem_req && imem_ack) obs_q.push_back(imem_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (phase == 5'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    do_reset();
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
    checks++; if (phase !== 5'b0) $display("FAIL rst_phase: got %b want 00000", phase); else passed++;
    checks++; if (COMMAND !== 16'h0) $display("FAIL rst_cmd: got %h want 0000", COMMAND); else passed++;
    checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else passed++;
    checks++; if (pc !== 16'h0) $display("FAIL rst_pc: got %h want 0000", pc); else passed++;
    checks++; if (pc_w !== 4'hF) $display("FAIL rst_pc_w: got %h want f", pc_w); else passed++;
  endtask

  task automatic test_phases();
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    logic [4:0] eph [7] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0, 5'd1};
`else
    logic [4:0] eph [6] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd1};
`endif
    bit ok;
    logic [15:0] e, o;
    clear_mem();
    do_reset();
    wait_n = 0;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    run = 1'b1;
    foreach (eph[i]) begin
      @(negedge clk);
      checks++; if (phase !== eph[i]) $display("FAIL phase_seq[%0d]: got %b want %b", i, phase, eph[i]); else passed++;
    end
    checks++; if (imem_addr !== 16'd1 || imem_req !== 1'b1) $display("FAIL next_fetch: got addr %h req %b want 0001 1", imem_addr, imem_req); else passed++;
    run = 1'b0;
    wait_idle(20, ok);
    checks++; if (!ok) $display("FAIL phases_idle: got busy want idle"); else passed++;
    #2;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL phases_fetch_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL phases_fetch_addr: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_wait_states();
    int req = 0;
    int cyc = 0;
    bit early = 1'b0;
    bit seen = 1'b0;
    bit ok;
    logic [15:0] e, o;
    clear_mem();
    mem[0] = 16'h1234;
    do_reset();
    wait_n = 3;
    exp_q.push_back(16'd0);
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (phase != 5'b0) cyc++;
      if (imem_req) begin
        req++;
        if (COMMAND !== 16'h0) early = 1'b1;
      end
      if (phase == 5'b10000) begin run = 1'b0; seen = 1'b1; break; end
    end
    checks++; if (!seen) $display("FAIL wait_p5: got no P5 want P5 within budget"); else passed++;
    checks++; if (req != 4) $display("FAIL wait_req_cycles: got %0d want 4", req); else passed++;
    checks++; if (cyc != 8) $display("FAIL wait_instr_cycles: got %0d want 8", cyc); else passed++;
    checks++; if (early) $display("FAIL wait_cmd_early: got change before ack want hold"); else passed++;
    checks++; if (COMMAND !== 16'h1234 || cmd_valid !== 1'b1) $display("FAIL wait_cmd: got %h v%b want 1234 v1", COMMAND, cmd_valid); else passed++;
    wait_idle(20, ok);
    checks++; if (!ok) $display("FAIL wait_idle: got busy want idle"); else passed++;
    wait_n = 0;
    #2;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL wait_fetch_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL wait_fetch_addr: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_branch(input bit bt, input logic [15:0] nxt);
    bit ok = 1'b0;
    logic [15:0] e, o;
    clear_mem();
    mem[5] = BR_WORD;
    do_reset();
    branch_taken = bt;
    branch_target = 16'h0040;
    for (int k = 0; k < 6; k++) exp_q.push_back(16'(k));
    exp_q.push_back(nxt);
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (obs_q.size() >= 7) begin ok = 1'b1; break; end
    end
    run = 1'b0;
    checks++; if (!ok) $display("FAIL br%0d_progress: got %0d fetches want 7", bt, obs_q.size()); else passed++;
    wait_idle(20, ok);
    checks++; if (!ok) $display("FAIL br%0d_idle: got busy want idle", bt); else passed++;
    #2;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL br%0d_fetch_count: got %0d want %0d", bt, obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL br%0d_fetch_addr: got %h want %h", bt, o, e); else passed++;
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_halt();
    bit seen = 1'b0;
    bit leak = 1'b0;
    logic [15:0] e, o;
    clear_mem();
    mem[3] = HLT_WORD;
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(16'(k));
    run = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (phase == 5'b10000 && COMMAND == HLT_WORD) begin
        @(negedge clk);
        checks++; if (halted !== 1'b1) $display("FAIL halt_assert: got %b want 1", halted); else passed++;
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) $display("FAIL halt_p5: got no HLT P5 want one"); else passed++;
    repeat (10) begin
      @(negedge clk);
      if (imem_req || phase != 5'b0 || !halted) leak = 1'b1;
    end
    checks++; if (leak) $display("FAIL halt_hold: got activity want halted quiet"); else passed++;
    #2;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL halt_fetch_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL halt_fetch_addr: got %h want %h", o, e); else passed++;
    end
    rst_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b0) $display("FAIL halt_reset_halted: got %b want 0", halted); else passed++;
    checks++; if (pc !== 16'h0) $display("FAIL halt_reset_pc: got %h want 0000", pc); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_fetch();
    clear_mem();
    do_reset();
    wait_n = 5;
    run = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) $display("FAIL midrst_req_before: got %b want 1", imem_req); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || phase !== 5'b0) $display("FAIL midrst_req_after: got req %b phase %b want 0 00000", imem_req, phase); else passed++;
    run = 1'b0;
    rst_n = 1'b1;
    wait_n = 0;
    @(negedge clk);
    #2;
    checks++; if (obs_q.size() != 0) $display("FAIL midrst_fetch_count: got %0d want 0", obs_q.size()); else passed++;
    obs_q.delete();
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (pc_w !== 4'hF) $display("FAIL wrap_start_pc: got %h want f", pc_w); else passed++;
    @(negedge clk);
    checks++; if (ph_w !== 5'b0) $display("FAIL wrap_ack_outside_fetch: got phase %b want 00000", ph_w); else passed++;
    run_w = 1'b1;
    @(negedge clk);
    checks++; if (ph_w !== 5'b00001 || addr_w !== 4'hF || req_w !== 1'b1) $display("FAIL wrap_fetch: got ph %b addr %h req %b want 00001 f 1", ph_w, addr_w, req_w); else passed++;
    run_w = 1'b0;
    @(negedge clk);
    checks++; if (pc_w !== 4'h0 || cv_w !== 1'b1) $display("FAIL wrap_pc: got %h v%b want 0 v1", pc_w, cv_w); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (ph_w !== 5'b0 || halted_w !== 1'b0 || cmd_w !== 16'h0) $display("FAIL wrap_idle: got ph %b h%b cmd %h want 00000 h0 0000", ph_w, halted_w, cmd_w); else passed++;
  endtask

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    bit moved = 1'b0;
    bit ok;
    logic [15:0] e, o;
    clear_mem();
    do_reset();
    step = 1'b0;
    run = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (phase != 5'b0) moved = 1'b1;
    end
    checks++; if (moved) $display("FAIL step_no_pulse: got start want idle"); else passed++;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16'(k));
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      checks++; if (phase !== 5'b00001) $display("FAIL step_start[%0d]: got %b want 00001", k, phase); else passed++;
      wait_idle(20, ok);
      repeat (3) @(negedge clk);
      checks++; if (!ok || phase !== 5'b0) $display("FAIL step_idle[%0d]: got phase %b want 00000", k, phase); else passed++;
    end
    run = 1'b0;
    #2;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL step_fetch_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL step_fetch_addr: got %h want %h", o, e); else passed++;
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_phases();
    test_wait_states();
    test_branch(1'b1, 16'h0040);
    test_branch(1'b0, 16'h0006);
    test_halt();
    test_reset_mid_fetch();
    test_wrap();
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
